vga_timing: RTL
===============

# vga_timing

Raster timing generator for the 640×480 @ 60 Hz VGA path. Runs on the pixel clock and produces the coordinates and data-valid strobe that the pattern generator consumes, plus the HSYNC/VSYNC pins. The syncs are delayed so they line up with the pattern generator's registered RGB outputs. Counter numbering puts blanking first, so the visible region is x 160..799 and y 45..524.

## Interface
- `H_FP` = 16: horizontal front porch, pixels.
- `H_SYNC` = 96: horizontal sync width, pixels.
- `H_BP` = 48: horizontal back porch, pixels.
- `H_ACTIVE` = 640: visible pixels per line.
- `V_FP` = 10: vertical front porch, lines.
- `V_SYNC` = 2: vertical sync width, lines.
- `V_BP` = 33: vertical back porch, lines.
- `V_ACTIVE` = 480: visible lines per frame.
- `H_POL` = 0: hSync asserted level (0 = active-low).
- `V_POL` = 0: vSync asserted level (0 = active-low).
- `SYNC_DELAY` = 1: pipeline stages applied to hSync/vSync, range 0..4.
- `pixelClk` in 1: pixel clock, 25.175 MHz nominal.
- `reset` in 1: asynchronous, active-high reset.
- `xCor` out 10: horizontal counter, 0..H_TOTAL-1.
- `yCor` out 10: vertical counter, 0..V_TOTAL-1.
- `dValid` out 1: high when (xCor, yCor) is inside the visible region.
- `hSync` out 1: horizontal sync pin, delayed by SYNC_DELAY.
- `vSync` out 1: vertical sync pin, delayed by SYNC_DELAY.
- `lineStart` out 1: one-cycle pulse on horizontal wrap.
- `frameStart` out 1: one-cycle pulse on frame wrap.

## Operation
- Derived totals: H_TOTAL = H_FP+H_SYNC+H_BP+H_ACTIVE (800) and V_TOTAL = V_FP+V_SYNC+V_BP+V_ACTIVE (525). Both must be ≤ 1024; an elaboration-time assertion rejects larger values.
- Horizontal regions (x):
  - front porch 0..H_FP-1
  - sync H_FP..H_FP+H_SYNC-1 (16..111)
  - back porch 112..159
  - active H_BLANK..H_TOTAL-1 (160..799), where H_BLANK = H_FP+H_SYNC+H_BP
- Vertical regions (y), same ordering: front porch 0..9, sync 10..11, back porch 12..44, active 45..524.
- Counting: xCor increments every cycle. At H_TOTAL-1, xCor wraps to 0 and yCor increments. At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
- dValid is true when xCor ≥ H_BLANK and yCor ≥ V_BLANK. It is registered from the next-count values, so it is glitch-free and aligned with xCor/yCor in the same cycle.
- Raw syncs:
  - hSyncRaw = H_POL while xCor is in the sync region, otherwise ~H_POL.
  - vSyncRaw is defined the same way on yCor, using V_POL.
  - Both are registered from the next-count values, so they are aligned with xCor/yCor.
- hSync/vSync are the raw syncs passed through a SYNC_DELAY-stage shift register. SYNC_DELAY = 0 means pass-through.
- lineStart is high in the cycle where xCor == 0 following a wrap.
- frameStart is high in the cycle where (xCor, yCor) == (0, 0) following a wrap.

## Timing
- Reset values, held while `reset` is high:
  - xCor = 0, yCor = 0, dValid = 0
  - lineStart = 0, frameStart = 0
  - hSync = ~H_POL, vSync = ~V_POL (deasserted level), including every delay stage
- First rising edge after reset deasserts: xCor = 1. The (0,0) state during reset does not produce a frameStart or lineStart pulse.
- Latency:
  - xCor, yCor and dValid describe the same pixel.
  - hSync/vSync lag them by exactly SYNC_DELAY cycles.
  - The pattern generator adds one register, so default SYNC_DELAY = 1 aligns the sync pins with RGB.
- Reset asserted mid-line or mid-frame: all outputs and delay stages go to their reset values immediately (asynchronously). Counting restarts at 0 with no partial-frame pulse.
- Frame period is H_TOTAL × V_TOTAL = 420 000 cycles. Line period is 800 cycles. hSync is low for 96 cycles per line; vSync is low for 2 lines (1600 cycles) per frame.

## Structure
- `vga_pkg` holds:
  - the default timing constants
  - the derived H_TOTAL, V_TOTAL, H_BLANK, V_BLANK
  - `typedef logic [9:0] coord_t`, used for xCor/yCor here and in the pattern generator
- Sub-module `sync_delay` is a parameterised-depth shift register with an async reset value. It is instantiated once, 2 bits wide, to carry hSync and vSync.

## Test plan
- Reset: hold reset for 5 cycles → xCor = 0, yCor = 0, dValid = 0, hSync = 1, vSync = 1, frameStart = 0. First edge after release → xCor = 1.
- Horizontal sync: SYNC_DELAY = 1 → hSync falls one cycle after xCor == 16, stays low for exactly 96 cycles, and rises one cycle after xCor == 112.
- Active window: dValid first rises at (160, 45) and is low at (159, 45) and at (160, 44). Per frame, dValid is high for exactly 307 200 cycles.
- Wrap: (799, 10) → (0, 11) with lineStart = 1. (799, 524) → (0, 0) with frameStart = 1 and lineStart = 1. Consecutive frameStart pulses are exactly 420 000 cycles apart.
- vSync: low for yCor 10..11 (1600 cycles), shifted by SYNC_DELAY. SYNC_DELAY = 0 → vSync changes in the same cycle as yCor.
- Mid-frame reset: assert reset at (400, 300) → outputs go to reset values without waiting for a clock edge. After release, counting restarts from (0, 0) and the first frameStart occurs 420 000 cycles later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the coordinate type used by the raster
// generator and the pattern generator.
package vga_pkg;

  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_ACTIVE = 640;

  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_ACTIVE = 480;

  localparam int H_BLANK  = H_FP + H_SYNC + H_BP;
  localparam int V_BLANK  = V_FP + V_SYNC + V_BP;
  localparam int H_TOTAL  = H_BLANK + H_ACTIVE;
  localparam int V_TOTAL  = V_BLANK + V_ACTIVE;

  localparam int COORD_W  = 10;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register with an asynchronous reset value.
// DEPTH = 0 degenerates to a wire.
module sync_delay #(
  parameter int           W       = 1,
  parameter int           DEPTH   = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         pixelClk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH-1:0][W-1:0] stage;

    // Shift one stage per clock; every stage returns to RST_VAL on reset.
    always_ff @(posedge pixelClk or posedge reset) begin
      if (reset) begin
        stage <= {DEPTH{RST_VAL}};
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: blanking-first counter numbering, registered
// coordinates/strobes, and syncs delayed to line up with registered RGB.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int SYNC_DELAY = 1
) (
  input  logic   pixelClk,
  input  logic   reset,
  output coord_t xCor,
  output coord_t yCor,
  output logic   dValid,
  output logic   hSync,
  output logic   vSync,
  output logic   lineStart,
  output logic   frameStart
);

  localparam int H_BLK = H_FP + H_SYNC + H_BP;
  localparam int V_BLK = V_FP + V_SYNC + V_BP;
  localparam int H_TOT = H_BLK + H_ACTIVE;
  localparam int V_TOT = V_BLK + V_ACTIVE;

  localparam coord_t X_LAST = coord_t'(H_TOT - 1);
  localparam coord_t Y_LAST = coord_t'(V_TOT - 1);
  localparam coord_t X_VIS  = coord_t'(H_BLK);
  localparam coord_t Y_VIS  = coord_t'(V_BLK);
  localparam coord_t HS_LO  = coord_t'(H_FP);
  localparam coord_t HS_HI  = coord_t'(H_FP + H_SYNC);
  localparam coord_t VS_LO  = coord_t'(V_FP);
  localparam coord_t VS_HI  = coord_t'(V_FP + V_SYNC);

  // Counters are 10 bits wide; reject timings that would not fit.
  if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
    $error("vga_timing: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
    $error("vga_timing: SYNC_DELAY must be in 0..4");
  end

  coord_t xNext, yNext;
  logic   xWrap;
  logic   hSyncRaw, vSyncRaw;
  logic [1:0] syncQ;

  // Next-count values; every registered output is decoded from these so it
  // describes the same pixel as xCor/yCor.
  always_comb begin
    xWrap = (xCor == X_LAST);
    xNext = xWrap ? '0 : xCor + coord_t'(1);
    yNext = yCor;
    if (xWrap) yNext = (yCor == Y_LAST) ? '0 : yCor + coord_t'(1);
  end

  // Raster counters, visible strobe, raw syncs and wrap pulses.
  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      xCor       <= '0;
      yCor       <= '0;
      dValid     <= 1'b0;
      hSyncRaw   <= ~H_POL;
      vSyncRaw   <= ~V_POL;
      lineStart  <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      xCor       <= xNext;
      yCor       <= yNext;
      dValid     <= (xNext >= X_VIS) && (yNext >= Y_VIS);
      hSyncRaw   <= (xNext >= HS_LO && xNext < HS_HI) ? H_POL : ~H_POL;
      vSyncRaw   <= (yNext >= VS_LO && yNext < VS_HI) ? V_POL : ~V_POL;
      lineStart  <= (xNext == '0);
      frameStart <= (xNext == '0) && (yNext == '0);
    end
  end

  sync_delay #(
    .W      (2),
    .DEPTH  (SYNC_DELAY),
    .RST_VAL({~V_POL, ~H_POL})
  ) u_sync_delay (
    .pixelClk(pixelClk),
    .reset   (reset),
    .d       ({vSyncRaw, hSyncRaw}),
    .q       (syncQ)
  );

  assign hSync = syncQ[0];
  assign vSync = syncQ[1];

endmodule
